// File: rtl/dtc_vote_collector.sv
// Majority-vote reducer for the classifier label stream: one winning class per window of labels.
// Optional DTC_VOTE_CONF_EN adds the out_conf port carrying the winning count.
module dtc_vote_collector #(
   parameter int unsigned CLS_W  = 3,
   parameter int unsigned WINDOW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CLS_W-1:0] in_cls,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CLS_W-1:0] out_cls
`ifdef DTC_VOTE_CONF_EN
   ,
   output logic [7:0]       out_conf
`endif
);

   localparam int unsigned NCLS    = 2 ** CLS_W;
   localparam logic [7:0]  WIN_CNT = 8'(WINDOW);

   typedef enum logic {StAccum, StReport} state_t;

   state_t           state;
   logic [7:0]       cnt [NCLS];
   logic [7:0]       cnt_nxt [NCLS];
   logic [7:0]       samples;
   logic [7:0]       samples_nxt;
   logic             accept;
   logic             close;
   logic [CLS_W-1:0] best_cls;
   logic [7:0]       best_cnt;

   assign accept = in_valid & in_ready;

   always_comb begin
      for (int unsigned i = 0; i < NCLS; i++) begin
         cnt_nxt[i] = cnt[i];
      end
      if (accept) begin
         cnt_nxt[in_cls] = cnt[in_cls] + 8'd1;
      end
      samples_nxt = samples + {7'd0, accept};
      close = (state == StAccum) &&
              ((accept && (samples_nxt == WIN_CNT)) || (flush && ((samples != 8'd0) || accept)));
   end

   // Strict compare keeps the lowest index on ties; counts include the closing beat.
   always_comb begin
      best_cls = '0;
      best_cnt = cnt_nxt[0];
      for (int unsigned i = 1; i < NCLS; i++) begin
         if (cnt_nxt[i] > best_cnt) begin
            best_cnt = cnt_nxt[i];
            best_cls = CLS_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StAccum;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_cls   <= '0;
`ifdef DTC_VOTE_CONF_EN
         out_conf  <= 8'd0;
`endif
         samples   <= 8'd0;
         for (int unsigned i = 0; i < NCLS; i++) begin
            cnt[i] <= 8'd0;
         end
      end else begin
         unique case (state)
            StAccum: begin
               if (accept) begin
                  samples <= samples_nxt;
                  for (int unsigned i = 0; i < NCLS; i++) begin
                     cnt[i] <= cnt_nxt[i];
                  end
               end
               if (close) begin
                  state     <= StReport;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
                  out_cls   <= best_cls;
`ifdef DTC_VOTE_CONF_EN
                  out_conf  <= best_cnt;
`endif
               end
            end
            StReport: begin
               if (out_ready) begin
                  state     <= StAccum;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  samples   <= 8'd0;
                  for (int unsigned i = 0; i < NCLS; i++) begin
                     cnt[i] <= 8'd0;
                  end
               end
            end
            default: state <= StAccum;
         endcase
      end
   end

endmodule
